// File: rtl/booth_acc_pkg.sv
// ---------------------------------------------------------------------------
// booth_acc_pkg
//
// Shared definitions for the Booth multiplier accumulator stage.
//
// Contents:
//   DEF_PROD_W / DEF_ACC_W / DEF_CNT_W   default product, accumulator and
//                                       term counter widths
//   acc_state_t                         sequence FSM states
//   SAT_MAX(acc_w) / SAT_MIN(acc_w)     signed clamp limits for an
//                                       accumulator of acc_w bits
//
// The saturation limits are only consumed when BOOTH_ACC_SAT_EN is defined,
// but they live here so any block can reason about the accumulator range.
// ---------------------------------------------------------------------------
package booth_acc_pkg;

    localparam int DEF_PROD_W = 16;
    localparam int DEF_ACC_W  = 24;
    localparam int DEF_CNT_W  = 8;

    // IDLE  : nothing accumulated yet (acc and count are zero)
    // ACCUM : at least one term has been folded into the accumulator
    // HOLD  : a finished result is being presented downstream
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } acc_state_t;

    // Largest positive value representable in acc_w signed bits.
    function automatic longint SAT_MAX(input int acc_w);
        return (longint'(1) <<< (acc_w - 1)) - longint'(1);
    endfunction

    // Most negative value representable in acc_w signed bits.
    function automatic longint SAT_MIN(input int acc_w);
        return -(longint'(1) <<< (acc_w - 1));
    endfunction

endpackage

// File: rtl/booth_acc_sat_add.sv
// ---------------------------------------------------------------------------
// booth_acc_sat_add
//
// Combinational adder that folds one signed product into the running
// accumulator value.
//
// Configuration macro: BOOTH_ACC_SAT_EN
//   defined     - the sum is formed one bit wider than the accumulator; on
//                 signed overflow the result clamps to the positive or
//                 negative limit and 'overflow' is raised.
//   not defined - the sum wraps in two's complement and 'overflow' is 0,
//                 so nothing downstream ever records saturation.
//
// Ports:
//   acc       in   ACC_W   current accumulator (signed)
//   product   in   PROD_W  term to add (signed)
//   sum       out  ACC_W   next accumulator value
//   overflow  out  1       the sum was clamped this cycle
// ---------------------------------------------------------------------------
module booth_acc_sat_add
    import booth_acc_pkg::*;
#(
    parameter int PROD_W = DEF_PROD_W,
    parameter int ACC_W  = DEF_ACC_W
) (
    input  logic [ACC_W-1:0]  acc,
    input  logic [PROD_W-1:0] product,
    output logic [ACC_W-1:0]  sum,
    output logic              overflow
);

`ifdef BOOTH_ACC_SAT_EN

    localparam logic [ACC_W-1:0] SAT_HI = ACC_W'(SAT_MAX(ACC_W));
    localparam logic [ACC_W-1:0] SAT_LO = ACC_W'(SAT_MIN(ACC_W));

    logic [ACC_W:0] wide_sum;

    // One guard bit above the accumulator: the two top bits disagree exactly
    // when the true signed sum does not fit, and the guard bit then tells
    // which direction it left the range in.
    always_comb begin
        wide_sum = {acc[ACC_W-1], acc}
                 + {{(ACC_W + 1 - PROD_W){product[PROD_W-1]}}, product};
        overflow = wide_sum[ACC_W] ^ wide_sum[ACC_W-1];
        sum      = wide_sum[ACC_W-1:0];
        if (overflow) begin
            sum = wide_sum[ACC_W] ? SAT_LO : SAT_HI;
        end
    end

`else

    // Wrapping mode: the carry out of the top bit is simply discarded.
    always_comb begin
        sum      = acc + {{(ACC_W - PROD_W){product[PROD_W-1]}}, product};
        overflow = 1'b0;
    end

`endif

endmodule

// File: rtl/booth_accumulator.sv
// ---------------------------------------------------------------------------
// booth_accumulator
//
// MAC back end for the signed Booth multiplier. Accepts a stream of signed
// products over a valid/ready handshake, sums them into a wide accumulator
// and, when a sequence terminates, holds the dot-product result until the
// consumer takes it.
//
// A sequence terminates on a term flagged in_last, or automatically when
// the term counter reaches its all-ones value (the counter never wraps).
//
// Configuration macro: BOOTH_ACC_SAT_EN (see booth_acc_sat_add). When it is
// not defined the accumulator wraps and sat_flag stays 0.
//
// Ports:
//   clk        in   1       rising-edge clock
//   reset_n    in   1       asynchronous active-low reset
//   product    in   PROD_W  signed term
//   in_valid   in   1       product carries a term
//   in_last    in   1       term closes the sequence (qualified by in_valid)
//   in_ready   out  1       a term is accepted this cycle if in_valid
//   clear      in   1       drop the sequence in progress (ignored in HOLD)
//   acc_out    out  ACC_W   signed accumulated value
//   term_cnt   out  CNT_W   number of terms folded into acc_out
//   sat_flag   out  1       clamping happened during this sequence
//   out_valid  out  1       acc_out/term_cnt/sat_flag hold a final result
//   out_ready  in   1       consumer takes the result
//
// ACC_W must be larger than PROD_W.
// ---------------------------------------------------------------------------
module booth_accumulator
    import booth_acc_pkg::*;
#(
    parameter int PROD_W = DEF_PROD_W,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [PROD_W-1:0] product,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    input  logic              clear,
    output logic [ACC_W-1:0]  acc_out,
    output logic [CNT_W-1:0]  term_cnt,
    output logic              sat_flag,
    output logic              out_valid,
    input  logic              out_ready
);

    localparam logic [CNT_W-1:0] CNT_FULL = '1;

    acc_state_t       state_q;
    logic [ACC_W-1:0] acc_q;
    logic [CNT_W-1:0] cnt_q;
    logic             sat_q;
    logic             valid_q;

    logic             accept;
    logic [CNT_W-1:0] cnt_inc;
    logic             seq_done;
    logic [ACC_W-1:0] add_sum;
    logic             add_ovf;

    // in_ready depends only on the registered state and clear, so there is
    // never a combinational loop through the upstream valid or the
    // downstream ready.
    assign in_ready = (state_q != HOLD) && !clear;
    assign accept   = in_valid && in_ready;
    assign cnt_inc  = cnt_q + CNT_W'(1);

    // Stop on the flagged last term, or when this term fills the counter so
    // the next one can never push it past all-ones.
    assign seq_done = in_last || (cnt_inc == CNT_FULL);

    booth_acc_sat_add #(
        .PROD_W (PROD_W),
        .ACC_W  (ACC_W)
    ) u_sat_add (
        .acc      (acc_q),
        .product  (product),
        .sum      (add_sum),
        .overflow (add_ovf)
    );

    // Sequence FSM. Every visible output is a register here; out_valid is
    // set on the same edge that captures the closing term, so the result
    // and its valid appear together. In HOLD everything is frozen and clear
    // is deliberately ignored so a presented result can only leave through
    // the out_ready handshake (or reset).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE, ACCUM: begin
                    if (clear) begin
                        state_q <= IDLE;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        sat_q   <= 1'b0;
                        valid_q <= 1'b0;
                    end else if (accept) begin
                        acc_q <= add_sum;
                        cnt_q <= cnt_inc;
                        sat_q <= sat_q | add_ovf;
                        if (seq_done) begin
                            state_q <= HOLD;
                            valid_q <= 1'b1;
                        end else begin
                            state_q <= ACCUM;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        sat_q   <= 1'b0;
                        valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    acc_q   <= '0;
                    cnt_q   <= '0;
                    sat_q   <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign acc_out   = acc_q;
    assign term_cnt  = cnt_q;
    assign sat_flag  = sat_q;
    assign out_valid = valid_q;

endmodule
